// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register specifiers and the
// 64-bit machine word type.
package y86_pkg;

  typedef logic [63:0] word_t;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  localparam int unsigned NREGS = 15;

endpackage

// File: rtl/y86_writeback_regfile_if.sv
// Writeback-stage bundle: the instruction in flight plus its execute/memory results.
interface y86_writeback_regfile_if;
  import y86_pkg::*;

  logic       wb_valid;
  logic [3:0] icode;
  logic [3:0] rA;
  logic [3:0] rB;
  logic       cnd;
  logic       instr_err;
  word_t      valE;
  word_t      valM;

  modport master (
    output wb_valid, icode, rA, rB, cnd, instr_err, valE, valM
  );

  modport slave (
    input wb_valid, icode, rA, rB, cnd, instr_err, valE, valM
  );

endinterface

// File: rtl/y86_dst_select.sv
// Combinational destination-register selection (dstE/dstM) for Y86-64 SEQ;
// kept standalone so the PIPE hazard logic can reuse it.
module y86_dst_select
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  input  logic [3:0] rA,
  input  logic [3:0] rB,
  input  logic       cnd,
  output logic [3:0] dst_e,
  output logic [3:0] dst_m
);

  always_comb begin
    dst_e = RNONE;
    dst_m = RNONE;
    case (icode)
      IRRMOVQ:                      dst_e = cnd ? rB : RNONE;
      IIRMOVQ, IOPQ:                dst_e = rB;
      ICALL, IRET, IPUSHQ, IPOPQ:   dst_e = RRSP;
      default:                      dst_e = RNONE;
    endcase
    if (icode == IMRMOVQ || icode == IPOPQ)
      dst_m = rA;
  end

endmodule

// File: rtl/y86_writeback_regfile.sv
// Y86-64 SEQ writeback stage and architectural register file with sticky halt.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module y86_writeback_regfile
  import y86_pkg::*;
#(
  parameter word_t       RSP_RESET = 64'h0,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  y86_writeback_regfile_if.slave   wb,
  output word_t                    rax,
  output word_t                    rcx,
  output word_t                    rdx,
  output word_t                    rbx,
  output word_t                    rsp,
  output word_t                    rbp,
  output word_t                    rsi,
  output word_t                    rdi,
  output word_t                    r8,
  output word_t                    r9,
  output word_t                    r10,
  output word_t                    r11,
  output word_t                    r12,
  output word_t                    r13,
  output word_t                    r14,
  output logic                     halted
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]         retired_count
`endif
);

  logic [3:0] dst_e;
  logic [3:0] dst_m;
  logic       commit;
  logic       halt_req;
  word_t      rf [NREGS];

  y86_dst_select u_dst_select (
    .icode (wb.icode),
    .rA    (wb.rA),
    .rB    (wb.rB),
    .cnd   (wb.cnd),
    .dst_e (dst_e),
    .dst_m (dst_m)
  );

  assign commit   = wb.wb_valid && !halted && !wb.instr_err;
  assign halt_req = wb.wb_valid && ((wb.icode == IHALT) || wb.instr_err);

  // When both ports target the same register (popq %rsp) the valM write wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++)
        rf[i] <= '0;
      rf[RRSP] <= RSP_RESET;
    end else if (commit) begin
      if (dst_e != RNONE && dst_e != dst_m)
        rf[dst_e] <= wb.valE;
      if (dst_m != RNONE)
        rf[dst_m] <= wb.valM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      halted <= 1'b0;
    else if (halt_req)
      halted <= 1'b1;
  end

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      retired_count <= '0;
    else if (commit && wb.icode != IHALT)
      retired_count <= retired_count + 1'b1;
  end
`endif

  assign rax = rf[0];
  assign rcx = rf[1];
  assign rdx = rf[2];
  assign rbx = rf[3];
  assign rsp = rf[4];
  assign rbp = rf[5];
  assign rsi = rf[6];
  assign rdi = rf[7];
  assign r8  = rf[8];
  assign r9  = rf[9];
  assign r10 = rf[10];
  assign r11 = rf[11];
  assign r12 = rf[12];
  assign r13 = rf[13];
  assign r14 = rf[14];

endmodule

// File: tb/tb_y86_writeback_regfile.sv
// Directed testbench for y86_writeback_regfile; retire-counter scenarios are
// exercised when WB_RETIRE_CNT_EN is defined.
module tb_y86_writeback_regfile;

  logic clk;
  logic rst_n;
  logic [63:0] obs   [15];
  logic [63:0] exp_r [15];
  logic        halted;
  int unsigned total;
  int unsigned passed;

  logic [63:0] rax, rcx, rdx, rbx, rsp, rbp, rsi, rdi;
  logic [63:0] r8, r9, r10, r11, r12, r13, r14;
`ifdef WB_RETIRE_CNT_EN
  logic [3:0]  retired_count;
`endif

  y86_writeback_regfile_if wb ();

  y86_writeback_regfile #(
    .RSP_RESET (64'h200),
    .CNT_W     (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .wb     (wb.slave),
    .rax    (rax),
    .rcx    (rcx),
    .rdx    (rdx),
    .rbx    (rbx),
    .rsp    (rsp),
    .rbp    (rbp),
    .rsi    (rsi),
    .rdi    (rdi),
    .r8     (r8),
    .r9     (r9),
    .r10    (r10),
    .r11    (r11),
    .r12    (r12),
    .r13    (r13),
    .r14    (r14),
    .halted (halted)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retired_count (retired_count)
`endif
  );

  assign obs[0]  = rax;
  assign obs[1]  = rcx;
  assign obs[2]  = rdx;
  assign obs[3]  = rbx;
  assign obs[4]  = rsp;
  assign obs[5]  = rbp;
  assign obs[6]  = rsi;
  assign obs[7]  = rdi;
  assign obs[8]  = r8;
  assign obs[9]  = r9;
  assign obs[10] = r10;
  assign obs[11] = r11;
  assign obs[12] = r12;
  assign obs[13] = r13;
  assign obs[14] = r14;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one instruction for a single edge; returns 1 time unit after it.
  task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] ra,
                       input logic [3:0] rb, input logic c, input logic e,
                       input logic [63:0] ve, input logic [63:0] vm);
    wb.wb_valid  = v;
    wb.icode     = ic;
    wb.rA        = ra;
    wb.rB        = rb;
    wb.cnd       = c;
    wb.instr_err = e;
    wb.valE      = ve;
    wb.valM      = vm;
    @(posedge clk);
    #1;
    wb.wb_valid  = 1'b0;
    wb.instr_err = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) exp_r[i] = 64'h0;
    exp_r[4] = 64'h200;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 15; i++) begin
      total++;
      if (obs[i] !== exp_r[i])
        $display("FAIL reset_reg[%0d] got %h expected %h", i, obs[i], exp_r[i]);
      else passed++;
    end
    total++;
    if (halted !== 1'b0) $display("FAIL reset_halted got %b expected 0", halted);
    else passed++;
  endtask

  task automatic test_irmovq_cmov();
    @(negedge clk);
    wb.wb_valid = 1'b1; wb.icode = 4'h3; wb.rA = 4'hF; wb.rB = 4'h2;
    wb.cnd = 1'b0; wb.instr_err = 1'b0; wb.valE = 64'hDEAD; wb.valM = 64'h0;
    #1;
    total++;
    if (rdx !== 64'h0) $display("FAIL no_bypass rdx got %h expected 0", rdx);
    else passed++;
    drive(1, 4'h3, 4'hF, 4'h2, 0, 0, 64'hDEAD, 64'h0);
    exp_r[2] = 64'hDEAD;
    total++;
    if (rdx !== 64'hDEAD) $display("FAIL irmovq rdx got %h expected dead", rdx);
    else passed++;
    drive(1, 4'h2, 4'h0, 4'h1, 0, 0, 64'h7, 64'h0);
    total++;
    if (rcx !== 64'h0) $display("FAIL cmov_not_taken rcx got %h expected 0", rcx);
    else passed++;
    drive(1, 4'h2, 4'h0, 4'h1, 1, 0, 64'h5, 64'h0);
    exp_r[1] = 64'h5;
    total++;
    if (rcx !== 64'h5) $display("FAIL cmov_taken rcx got %h expected 5", rcx);
    else passed++;
  endtask

  task automatic test_popq();
    drive(1, 4'hB, 4'h4, 4'hF, 0, 0, 64'h108, 64'h55);
    exp_r[4] = 64'h55;
    total++;
    if (rsp !== 64'h55) $display("FAIL popq_rsp rsp got %h expected 55", rsp);
    else passed++;
    drive(1, 4'hB, 4'h0, 4'hF, 0, 0, 64'h110, 64'h77);
    exp_r[0] = 64'h77;
    exp_r[4] = 64'h110;
    total++;
    if (rax !== 64'h77) $display("FAIL popq_rax rax got %h expected 77", rax);
    else passed++;
    total++;
    if (rsp !== 64'h110) $display("FAIL popq_rsp_e rsp got %h expected 110", rsp);
    else passed++;
  endtask

  task automatic test_mem_and_misc();
    drive(1, 4'h5, 4'h7, 4'h2, 0, 0, 64'h999, 64'h1234);
    exp_r[7] = 64'h1234;
    drive(1, 4'h4, 4'h3, 4'h2, 1, 0, 64'h999, 64'h888);
    drive(1, 4'hA, 4'h5, 4'hF, 0, 0, 64'hF8, 64'h0);
    exp_r[4] = 64'hF8;
    drive(1, 4'h6, 4'h1, 4'h6, 0, 0, 64'h42, 64'h0);
    exp_r[6] = 64'h42;
    drive(1, 4'hC, 4'h0, 4'h1, 1, 0, 64'hBAD, 64'hBAD);
    drive(1, 4'h2, 4'hF, 4'hF, 1, 0, 64'hBAD, 64'hBAD);
    drive(0, 4'h3, 4'hF, 4'h5, 0, 0, 64'hBAD, 64'hBAD);
    drive(0, 4'h0, 4'hF, 4'hF, 0, 0, 64'h0, 64'h0);
    for (int i = 0; i < 15; i++) begin
      total++;
      if (obs[i] !== exp_r[i])
        $display("FAIL misc_reg[%0d] got %h expected %h", i, obs[i], exp_r[i]);
      else passed++;
    end
    total++;
    if (halted !== 1'b0) $display("FAIL invalid_halt halted got %b expected 0", halted);
    else passed++;
  endtask

  task automatic test_reset_midwrite();
    @(negedge clk);
    wb.wb_valid = 1'b1; wb.icode = 4'h3; wb.rA = 4'hF; wb.rB = 4'h8;
    wb.cnd = 1'b0; wb.instr_err = 1'b0; wb.valE = 64'hAAAA; wb.valM = 64'h0;
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (rdx !== 64'h0) $display("FAIL async_reset rdx got %h expected 0", rdx);
    else passed++;
    total++;
    if (rsp !== 64'h200) $display("FAIL async_reset rsp got %h expected 200", rsp);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (r8 !== 64'h0) $display("FAIL reset_drop_write r8 got %h expected 0", r8);
    else passed++;
    wb.wb_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) exp_r[i] = 64'h0;
    exp_r[4] = 64'h200;
    for (int i = 0; i < 15; i++) begin
      total++;
      if (obs[i] !== exp_r[i])
        $display("FAIL midreset_reg[%0d] got %h expected %h", i, obs[i], exp_r[i]);
      else passed++;
    end
  endtask

`ifdef WB_RETIRE_CNT_EN
  task automatic test_retire_count();
    do_reset();
    total++;
    if (retired_count !== 4'd0) $display("FAIL count_reset got %0d expected 0", retired_count);
    else passed++;
    drive(1, 4'h3, 4'hF, 4'h9, 0, 0, 64'h1, 64'h0);
    drive(0, 4'h3, 4'hF, 4'h9, 0, 0, 64'h1, 64'h0);
    drive(1, 4'h1, 4'hF, 4'hF, 0, 0, 64'h0, 64'h0);
    drive(1, 4'h7, 4'hF, 4'hF, 0, 0, 64'h0, 64'h0);
    drive(0, 4'h1, 4'hF, 4'hF, 0, 0, 64'h0, 64'h0);
    drive(1, 4'hD, 4'hF, 4'hF, 0, 0, 64'h0, 64'h0);
    drive(1, 4'h6, 4'h1, 4'hA, 0, 0, 64'h3, 64'h0);
    total++;
    if (retired_count !== 4'd5) $display("FAIL count_five got %0d expected 5", retired_count);
    else passed++;
    do_reset();
    for (int i = 0; i < 15; i++) drive(1, 4'h1, 4'hF, 4'hF, 0, 0, 64'h0, 64'h0);
    total++;
    if (retired_count !== 4'd15) $display("FAIL count_max got %0d expected 15", retired_count);
    else passed++;
    drive(1, 4'h1, 4'hF, 4'hF, 0, 0, 64'h0, 64'h0);
    total++;
    if (retired_count !== 4'd0) $display("FAIL count_wrap got %0d expected 0", retired_count);
    else passed++;
    drive(1, 4'h3, 4'hF, 4'h2, 0, 1, 64'h0, 64'h0);
    total++;
    if (retired_count !== 4'd0) $display("FAIL count_err got %0d expected 0", retired_count);
    else passed++;
  endtask
`endif

  task automatic test_halt();
    do_reset();
    drive(1, 4'h0, 4'hF, 4'hF, 0, 0, 64'h0, 64'h0);
    total++;
    if (halted !== 1'b1) $display("FAIL halt_set halted got %b expected 1", halted);
    else passed++;
    drive(1, 4'h3, 4'hF, 4'h3, 0, 0, 64'h9, 64'h0);
    total++;
    if (rbx !== 64'h0) $display("FAIL halt_block rbx got %h expected 0", rbx);
    else passed++;
    total++;
    if (halted !== 1'b1) $display("FAIL halt_sticky halted got %b expected 1", halted);
    else passed++;
    do_reset();
    drive(1, 4'h3, 4'hF, 4'h3, 0, 1, 64'h9, 64'h0);
    total++;
    if (rbx !== 64'h0) $display("FAIL err_nowrite rbx got %h expected 0", rbx);
    else passed++;
    total++;
    if (halted !== 1'b1) $display("FAIL err_halt halted got %b expected 1", halted);
    else passed++;
    drive(1, 4'h3, 4'hF, 4'h3, 0, 0, 64'h9, 64'h0);
    total++;
    if (rbx !== 64'h0) $display("FAIL err_block rbx got %h expected 0", rbx);
    else passed++;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst_n  = 1'b1;
    wb.wb_valid = 1'b0; wb.icode = 4'h1; wb.rA = 4'hF; wb.rB = 4'hF;
    wb.cnd = 1'b0; wb.instr_err = 1'b0; wb.valE = 64'h0; wb.valM = 64'h0;
    test_reset();
    test_irmovq_cmov();
    test_popq();
    test_mem_and_misc();
    test_reset_midwrite();
`ifdef WB_RETIRE_CNT_EN
    test_retire_count();
`endif
    test_halt();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/y86_writeback_regfile.md
Name: y86_writeback_regfile

Overview:
- Writeback stage plus architectural register file for the Y86-64 SEQ processor.
- Consumes the execute result (valE) and the memory result (valM) of the instruction in flight, together with icode, rA, rB and the condition flag cnd.
- Derives dstE/dstM internally and commits writes on the clock edge.
- Continuously drives the 15 register values (rax..r14) that the decode stage reads. Also latches processor halt and counts retired instructions.

Parameters:
- RSP_RESET, 64'h0, reset value of rsp (register 4); all other registers reset to 0.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wb_valid  in  1  instruction in writeback is valid this cycle; no state changes when low.
- icode  in  4  instruction code.
- rA  in  4  register A specifier; 4'hF = none.
- rB  in  4  register B specifier; 4'hF = none.
- cnd  in  1  condition result from execute (cmovXX).
- instr_err  in  1  instruction or address error flagged upstream.
- valE  in  64  ALU result.
- valM  in  64  memory read data.
- rax, rcx, rdx, rbx, rsp, rbp, rsi, rdi, r8, r9, r10, r11, r12, r13, r14  out  64 each  registered architectural state.
- halted  out  1  sticky halt status.
- retired_count  out  CNT_W  retired instruction count (present only with the macro).

Behaviour:
- Reset (async, rst_n low):
  - all registers = 0, except rsp = RSP_RESET.
  - halted = 0; retired_count = 0.
  - Takes effect immediately, mid-instruction included; any write pending on that edge is lost.
- dstE (combinational):
  - icode 2: rB if cnd=1, else 4'hF.
  - icode 3 and 6: rB.
  - icode 8, 9, A, B: 4 (rsp).
  - all other icodes: 4'hF.
- dstM (combinational):
  - icode 5 and B: rA.
  - all other icodes: 4'hF.
- Commit on rising clk when wb_valid=1 and halted=0 and instr_err=0:
  - reg[dstE] <= valE when dstE != F.
  - reg[dstM] <= valM when dstM != F.
- Write latency: outputs reflect the new value the cycle after the edge. There is no same-cycle bypass; decode sees the old value until the edge.
- dstE == dstM (e.g. popq %rsp): the valM write wins and the valE write is dropped.
- Specifier 4'hF never writes; there is no 16th register.
- Halt:
  - wb_valid=1 with icode 0, or wb_valid=1 with instr_err=1, sets halted <= 1 on the edge.
  - halted stays set until reset. While halted, all register writes and counting are suppressed.
  - A halt instruction or an erroring instruction performs no register write itself.
- Illegal icode (C..F) with instr_err=0: no register write, counted as retired.
- wb_valid=0: no writes, no count, halted unchanged.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- Defined:
  - retired_count port exists.
  - Increments by 1 on each edge with wb_valid=1, halted=0, instr_err=0, icode != 0.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

Decomposition:
- Package y86_pkg:
  - icode constants: IHALT, INOP, IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IJXX, ICALL, IRET, IPUSHQ, IPOPQ.
  - register index constants: RRSP=4, RNONE=4'hF.
  - 64-bit word typedef.
- Sub-module y86_dst_select: purely combinational icode/rA/rB/cnd -> dstE/dstM. It is reusable later by the PIPE design's hazard unit.

Test Plan:
- Reset with RSP_RESET=64'h200 -> rsp=64'h200, all other registers 0, halted=0; assert rst_n low mid-write -> registers return to reset values immediately.
- irmovq (icode 3) rB=2, valE=64'hDEAD -> rdx=64'hDEAD one cycle later. cmovXX (icode 2) rB=1 with cnd=0 -> rcx unchanged; with cnd=1, valE=5 -> rcx=5.
- popq (icode B) rA=4, valE=64'h108, valM=64'h55 -> rsp=64'h55, i.e. the valM write wins. popq rA=0 -> rax=valM and rsp=valE in the same edge.
- mrmovq (icode 5) rA=7, valM=64'h1234 -> rdi=64'h1234. rmmovq (icode 4) -> no register changes.
- halt (icode 0) -> halted=1. A subsequent irmovq rB=3, valE=9 -> rbx unchanged. Same result when instr_err=1 is presented with any icode.
- With WB_RETIRE_CNT_EN defined: 5 valid non-halt instructions plus 2 wb_valid=0 cycles -> retired_count=5. Preload near max (CNT_W=4, 15 retires, then one more) -> count wraps to 0.
